// File: rtl/ibuf_fifo_pkg.sv
// Shared router constants for the input buffer: payload width, direction bit indices, default depth.
package ibuf_fifo_pkg;
  localparam int PKT_W        = 32;
  localparam int IBUF_DEPTH   = 4;
  localparam int IBUF_NUM_DIR = 5;
  localparam int DIR_N        = 0;
  localparam int DIR_S        = 1;
  localparam int DIR_E        = 2;
  localparam int DIR_W        = 3;
  localparam int DIR_B        = 4;
endpackage

// File: rtl/ibuf_fifo_ring_store.sv
// Ring storage for the input buffer: entry array, wrapping pointers, occupancy, full/empty.
module ibuf_ring_store #(
  parameter int W     = 37,
  parameter int DEPTH = 4,
  parameter int PTR_W = $clog2(DEPTH),
  parameter int OCC_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [W-1:0]     wr_data,
  input  logic             rd_en,
  output logic [W-1:0]     rd_data,
  output logic [W-1:0]     nxt_data,
  output logic [OCC_W-1:0] count,
  output logic             full,
  output logic             empty
);
  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] rd_ptr_nxt;

  // DEPTH is a power of two, so pointers wrap by natural overflow.
  assign rd_ptr_nxt = rd_ptr + PTR_W'(1);
  assign rd_data    = mem[rd_ptr];
  assign nxt_data   = mem[rd_ptr_nxt];
  assign full       = (count == OCC_W'(DEPTH));
  assign empty      = (count == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (wr_en) begin
        mem[wr_ptr] <= wr_data;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (rd_en) rd_ptr <= rd_ptr_nxt;
      case ({wr_en, rd_en})
        2'b10:   count <= count + OCC_W'(1);
        2'b01:   count <= count - OCC_W'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/ibuf_fifo.sv
// Router input buffer with per-direction multicast retirement of the head entry.
// Optional head stall counter enabled by defining IBUF_STALL_CNT_EN.
module ibuf_fifo
  import ibuf_fifo_pkg::*;
#(
  parameter int PYLD_W  = PKT_W,
  parameter int DEPTH   = IBUF_DEPTH,
  parameter int NUM_DIR = IBUF_NUM_DIR,
  parameter int CNT_W   = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     ibuf_vld,
  output logic                     ibuf_rdy,
  input  logic [NUM_DIR-1:0]       route_req,
  input  logic [PYLD_W-1:0]        payload_i,
  output logic [NUM_DIR-1:0]       arb_req,
  input  logic [NUM_DIR-1:0]       arb_gnt,
  input  logic [NUM_DIR-1:0]       obuf_rdy,
  output logic [PYLD_W-1:0]        payload_o,
`ifdef IBUF_STALL_CNT_EN
  output logic [CNT_W-1:0]         stall_cnt,
`endif
  output logic [$clog2(DEPTH):0]   occupancy
);
  localparam int W     = NUM_DIR + PYLD_W;
  localparam int OCC_W = $clog2(DEPTH) + 1;

  logic [W-1:0]       rd_data;
  logic [W-1:0]       nxt_data;
  logic               full;
  logic               empty;
  logic               push;
  logic               pop;
  logic [NUM_DIR-1:0] head_mask;
  logic [NUM_DIR-1:0] head_mask_d;
  logic [NUM_DIR-1:0] clr;
  logic [NUM_DIR-1:0] remain;

  // Handshake: a flit transfers on a cycle where ibuf_vld and ibuf_rdy are both high;
  // ibuf_rdy depends only on the registered count. A zero route mask is accepted and dropped.
  assign ibuf_rdy = !full;
  assign push     = ibuf_vld && ibuf_rdy && (route_req != '0);

  assign arb_req   = empty ? '0 : head_mask;
  assign payload_o = rd_data[PYLD_W-1:0];
  assign clr       = arb_gnt & obuf_rdy & arb_req;
  assign remain    = head_mask & ~clr;
  assign pop       = !empty && (remain == '0);

  ibuf_ring_store #(.W(W), .DEPTH(DEPTH)) u_store (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (push),
    .wr_data  ({route_req, payload_i}),
    .rd_en    (pop),
    .rd_data  (rd_data),
    .nxt_data (nxt_data),
    .count    (occupancy),
    .full     (full),
    .empty    (empty)
  );

  // On pop the next stored entry, or the flit arriving now if none is stored, becomes head.
  always_comb begin
    head_mask_d = remain;
    if (pop) begin
      if (occupancy > OCC_W'(1)) head_mask_d = nxt_data[W-1:PYLD_W];
      else if (push)             head_mask_d = route_req;
      else                       head_mask_d = '0;
    end else if (empty && push) begin
      head_mask_d = route_req;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) head_mask <= '0;
    else     head_mask <= head_mask_d;
  end

`ifdef IBUF_STALL_CNT_EN
  always_ff @(posedge clk) begin
    if (rst)
      stall_cnt <= '0;
    else if ((arb_req != '0) && (clr == '0) && (stall_cnt != '1))
      stall_cnt <= stall_cnt + CNT_W'(1);
  end
`endif
endmodule

// File: tb/tb_ibuf_fifo.sv
// Directed bench for ibuf_fifo: unicast, multicast, full/wrap, push+pop, reset.
module tb_ibuf_fifo;
  localparam int PW = 8;
  localparam int ND = 5;
  localparam int DP = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          ibuf_vld = 1'b0;
  logic          ibuf_rdy;
  logic [ND-1:0] route_req = '0;
  logic [PW-1:0] payload_i = '0;
  logic [ND-1:0] arb_req;
  logic [ND-1:0] arb_gnt = '0;
  logic [ND-1:0] obuf_rdy = '0;
  logic [PW-1:0] payload_o;
  logic [2:0]    occupancy;
`ifdef IBUF_STALL_CNT_EN
  logic [15:0]   stall_cnt;
`endif

  int n_vec = 0;
  int n_bad = 0;
  logic [ND+PW-1:0] exp_q[$];

  ibuf_fifo #(.PYLD_W(PW), .DEPTH(DP), .NUM_DIR(ND), .CNT_W(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .ibuf_vld  (ibuf_vld),
    .ibuf_rdy  (ibuf_rdy),
    .route_req (route_req),
    .payload_i (payload_i),
    .arb_req   (arb_req),
    .arb_gnt   (arb_gnt),
    .obuf_rdy  (obuf_rdy),
    .payload_o (payload_o),
`ifdef IBUF_STALL_CNT_EN
    .stall_cnt (stall_cnt),
`endif
    .occupancy (occupancy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout obs=running exp=finished");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1ns after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_one(input logic [ND-1:0] m, input logic [PW-1:0] p);
    ibuf_vld = 1'b1; route_req = m; payload_i = p;
    exp_q.push_back({m, p});
    step();
    ibuf_vld = 1'b0; route_req = '0;
  endtask

  task automatic drain_all();
    logic [ND+PW-1:0] e;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("drain_req", 32'(arb_req), 32'(e[ND+PW-1:PW]));
      check("drain_pyld", 32'(payload_o), 32'(e[PW-1:0]));
      arb_gnt = '1; obuf_rdy = '1;
      step();
      arb_gnt = '0; obuf_rdy = '0;
    end
    check("drain_occ", 32'(occupancy), 0);
  endtask

  initial begin
    // 1. reset then idle
    step(); step();
    rst = 1'b0;
    step();
    check("rst_rdy", 32'(ibuf_rdy), 1);
    check("rst_req", 32'(arb_req), 0);
    check("rst_occ", 32'(occupancy), 0);
    check("rst_pyld", 32'(payload_o), 0);

    // 2. unicast
    push_one(5'b00001, 8'hA5);
    check("uni_req", 32'(arb_req), 32'h01);
    check("uni_pyld", 32'(payload_o), 32'hA5);
    check("uni_occ", 32'(occupancy), 1);
    arb_gnt = 5'b00001; obuf_rdy = 5'b00001;
    step();
    arb_gnt = '0; obuf_rdy = '0;
    void'(exp_q.pop_front());
    check("uni_req_pop", 32'(arb_req), 0);
    check("uni_occ_pop", 32'(occupancy), 0);

    // 3. multicast
    push_one(5'b10101, 8'h3C);
    arb_gnt = 5'b00001; obuf_rdy = 5'b00000;
    step();
    check("mc_noobuf_req", 32'(arb_req), 32'h15);
    check("mc_noobuf_pyld", 32'(payload_o), 32'h3C);
    obuf_rdy = 5'b00001;
    step();
    check("mc_bit0_req", 32'(arb_req), 32'h14);
    check("mc_bit0_pyld", 32'(payload_o), 32'h3C);
    arb_gnt = 5'b10101; obuf_rdy = 5'b11111;
    step();
    arb_gnt = '0; obuf_rdy = '0;
    void'(exp_q.pop_front());
    check("mc_pop_req", 32'(arb_req), 0);
    check("mc_pop_occ", 32'(occupancy), 0);

    // 4. fill, hold, single pop, wrap
    for (int i = 0; i < 4; i++) push_one(5'b00010, 8'(8'h10 + i));
    check("full_rdy", 32'(ibuf_rdy), 0);
    check("full_occ", 32'(occupancy), 4);
    ibuf_vld = 1'b1; route_req = 5'b01000; payload_i = 8'h99;
    step();
    check("full_hold_occ", 32'(occupancy), 4);
    check("full_hold_pyld", 32'(payload_o), 32'h10);
    ibuf_vld = 1'b0; route_req = '0;
    arb_gnt = 5'b00010; obuf_rdy = '1;
    check("full_popcyc_rdy", 32'(ibuf_rdy), 0);
    step();
    arb_gnt = '0; obuf_rdy = '0;
    void'(exp_q.pop_front());
    check("pop1_rdy", 32'(ibuf_rdy), 1);
    check("pop1_occ", 32'(occupancy), 3);
    check("pop1_pyld", 32'(payload_o), 32'h11);
    push_one(5'b01001, 8'h14);
    drain_all();
    for (int i = 0; i < 4; i++) push_one(5'(i + 1), 8'(8'h20 + i));
    drain_all();

    // 5. push and pop together at occupancy 2, then a zero-mask flit
    push_one(5'b00100, 8'h50);
    push_one(5'b01000, 8'h51);
    ibuf_vld = 1'b1; route_req = 5'b10000; payload_i = 8'h52;
    arb_gnt = 5'b00100; obuf_rdy = 5'b00100;
    step();
    ibuf_vld = 1'b0; arb_gnt = '0; obuf_rdy = '0;
    check("pp_occ", 32'(occupancy), 2);
    check("pp_req", 32'(arb_req), 32'h08);
    check("pp_pyld", 32'(payload_o), 32'h51);
    ibuf_vld = 1'b1; route_req = 5'b00000; payload_i = 8'h77;
    check("zero_rdy", 32'(ibuf_rdy), 1);
    step();
    ibuf_vld = 1'b0;
    check("zero_occ", 32'(occupancy), 2);
    check("zero_req", 32'(arb_req), 32'h08);

    // 6. reset with 3 entries held
    push_one(5'b00001, 8'h60);
    check("pre_rst_occ", 32'(occupancy), 3);
    rst = 1'b1;
    step();
    rst = 1'b0;
    exp_q.delete();
    check("mid_rst_occ", 32'(occupancy), 0);
    check("mid_rst_req", 32'(arb_req), 0);
    check("mid_rst_rdy", 32'(ibuf_rdy), 1);
    check("mid_rst_pyld", 32'(payload_o), 0);

`ifdef IBUF_STALL_CNT_EN
    push_one(5'b00001, 8'h70);
    check("stall_start", 32'(stall_cnt), 0);
    for (int i = 0; i < 10; i++) step();
    check("stall_10", 32'(stall_cnt), 10);
    rst = 1'b1;
    step();
    rst = 1'b0;
    exp_q.delete();
    check("stall_rst", 32'(stall_cnt), 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
